// File: rtl/commit_sequencer_pkg.sv
// commit_sequencer_pkg: shared widths, the no-destination register code and FSM state encodings
package commit_sequencer_pkg;
   localparam int ROB_ID_W_DEF = 4;
   localparam int REG_W_DEF = 6;
   localparam int NO_DEST = 32;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STORE_WAIT = 2'd1,
      ST_FLUSH_HOLD = 2'd2
   } state_t;
endpackage

// File: rtl/commit_sequencer.sv
// commit_sequencer: retires the ROB head in order, handling stores, mispredicts and post-flush hold
//   clk, rst (sync, active-high), rdy (global enable)
//   head_*      : ROB head entry (valid, done, id, rd, val, is_store, is_br, miss, tgt)
//   rob_pop     : retire head this cycle
//   rf_*        : register-file write port (combinational, zero latency)
//   st_req/st_id/st_ack : store commit handshake with memory
//   mispredict/redirect_pc : flush pulse and registered redirect target
//   commit_cnt  : retired-instruction count
module commit_sequencer
   import commit_sequencer_pkg::*;
#(
   parameter int ROB_ID_W = ROB_ID_W_DEF,
   parameter int REG_W = REG_W_DEF,
   parameter int FLUSH_HOLD = 2
) (
   input logic clk,
   input logic rst,
   input logic rdy,
   input logic head_valid,
   input logic head_done,
   input logic [ROB_ID_W-1:0] head_id,
   input logic [REG_W-1:0] head_rd,
   input logic [31:0] head_val,
   input logic head_is_store,
   input logic head_is_br,
   input logic head_miss,
   input logic [31:0] head_tgt,
   output logic rob_pop,
   output logic rf_we,
   output logic [REG_W-1:0] rf_rd,
   output logic [ROB_ID_W-1:0] rf_q,
   output logic [31:0] rf_v,
   output logic st_req,
   output logic [ROB_ID_W-1:0] st_id,
   input logic st_ack,
   output logic mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] commit_cnt
);
   state_t state, state_nx;
   logic [3:0] hold_cnt, hold_nx;
   logic st_req_nx;
   logic [ROB_ID_W-1:0] st_id_nx;
   logic [31:0] redirect_nx;
   logic head_ready, has_dest;
   assign head_ready = head_valid && head_done;
   assign has_dest = (head_rd != '0) && (head_rd != REG_W'(NO_DEST));
   always_ff @(posedge clk)
      if (rst) begin
         state <= ST_IDLE;
         hold_cnt <= '0;
         st_req <= 1'b0;
         st_id <= '0;
         redirect_pc <= '0;
         commit_cnt <= '0;
      end else begin
         state <= state_nx;
         hold_cnt <= hold_nx;
         st_req <= st_req_nx;
         st_id <= st_id_nx;
         redirect_pc <= redirect_nx;
         commit_cnt <= commit_cnt + 32'(rob_pop);
      end
   // hold_cnt counts down from FLUSH_HOLD-1 so the hold state lasts exactly FLUSH_HOLD enabled cycles
   always_comb begin
      state_nx = state;
      hold_nx = hold_cnt;
      st_req_nx = st_req;
      st_id_nx = st_id;
      redirect_nx = redirect_pc;
      rob_pop = 1'b0;
      rf_we = 1'b0;
      mispredict = 1'b0;
      if (!rst && rdy)
         case (state)
            ST_IDLE:
               if (head_ready) begin
                  if (head_is_store) begin
                     st_req_nx = 1'b1;
                     st_id_nx = head_id;
                     state_nx = ST_STORE_WAIT;
                  end else begin
                     rob_pop = 1'b1;
                     rf_we = has_dest;
                     if (head_is_br && head_miss) begin
                        mispredict = 1'b1;
                        redirect_nx = head_tgt;
                        hold_nx = 4'(FLUSH_HOLD - 1);
                        state_nx = ST_FLUSH_HOLD;
                     end
                  end
               end
            ST_STORE_WAIT:
               if (st_ack) begin
                  rob_pop = 1'b1;
                  st_req_nx = 1'b0;
                  state_nx = ST_IDLE;
               end
            ST_FLUSH_HOLD: begin
               hold_nx = (hold_cnt == '0) ? '0 : hold_cnt - 4'd1;
               state_nx = (hold_cnt == '0) ? ST_IDLE : ST_FLUSH_HOLD;
            end
            default: state_nx = ST_IDLE;
         endcase
   end
   assign rf_rd = rf_we ? head_rd : '0;
   assign rf_q = rf_we ? head_id : '0;
   assign rf_v = rf_we ? head_val : '0;
endmodule

// File: tb/tb_commit_sequencer.sv
// tb_commit_sequencer: directed and randomized checks of commit_sequencer against a behavioural model
module tb_commit_sequencer;
   localparam int HOLD = 2;
   logic clk = 1'b0;
   logic rst, rdy, head_valid, head_done, head_is_store, head_is_br, head_miss, st_ack;
   logic [3:0] head_id;
   logic [5:0] head_rd;
   logic [31:0] head_val, head_tgt;
   logic rob_pop, rf_we, st_req, mispredict;
   logic [5:0] rf_rd;
   logic [3:0] rf_q, st_id;
   logic [31:0] rf_v, redirect_pc, commit_cnt;
   int total = 0;
   int bad = 0;
   bit m_store = 0;
   logic [3:0] m_sid = '0;
   int m_flush = 0;
   logic [31:0] m_pc = '0;
   logic [31:0] m_cnt = '0;

   commit_sequencer #(.FLUSH_HOLD(HOLD)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .head_valid(head_valid), .head_done(head_done), .head_id(head_id),
      .head_rd(head_rd), .head_val(head_val), .head_is_store(head_is_store),
      .head_is_br(head_is_br), .head_miss(head_miss), .head_tgt(head_tgt),
      .rob_pop(rob_pop), .rf_we(rf_we), .rf_rd(rf_rd), .rf_q(rf_q), .rf_v(rf_v),
      .st_req(st_req), .st_id(st_id), .st_ack(st_ack),
      .mispredict(mispredict), .redirect_pc(redirect_pc), .commit_cnt(commit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_head(input bit v, input bit d, input int id, input int rd, input logic [31:0] val,
                           input bit st, input bit br, input bit miss, input logic [31:0] tgt);
      head_valid = v; head_done = d; head_id = 4'(id); head_rd = 6'(rd); head_val = val;
      head_is_store = st; head_is_br = br; head_miss = miss; head_tgt = tgt;
   endtask

   // One cycle: settle inputs, compare against the model, advance the model, cross the clock edge.
   task automatic tick();
      bit e_pop, e_we, e_mis, hr;
      #1;
      e_pop = 0; e_we = 0; e_mis = 0;
      hr = head_valid && head_done;
      if (!rst && rdy) begin
         if (m_store) e_pop = st_ack;
         else if (m_flush == 0 && hr && !head_is_store) begin
            e_pop = 1;
            e_we = head_rd != 0 && head_rd != 32;
            e_mis = head_is_br && head_miss;
         end
      end
      check("rob_pop", 32'(rob_pop), 32'(e_pop));
      check("rf_we", 32'(rf_we), 32'(e_we));
      check("rf_rd", 32'(rf_rd), e_we ? 32'(head_rd) : 0);
      check("rf_q", 32'(rf_q), e_we ? 32'(head_id) : 0);
      check("rf_v", rf_v, e_we ? head_val : 0);
      check("mispredict", 32'(mispredict), 32'(e_mis));
      check("st_req", 32'(st_req), 32'(m_store));
      check("st_id", 32'(st_id), 32'(m_sid));
      check("redirect_pc", redirect_pc, m_pc);
      check("commit_cnt", commit_cnt, m_cnt);
      if (rst) begin
         m_store = 0; m_sid = '0; m_flush = 0; m_pc = '0; m_cnt = '0;
      end else if (rdy) begin
         if (m_store) m_store = !st_ack;
         else if (m_flush > 0) m_flush--;
         else if (hr && head_is_store) begin
            m_store = 1; m_sid = head_id;
         end else if (e_mis) begin
            m_pc = head_tgt; m_flush = HOLD;
         end
         m_cnt += 32'(e_pop);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1; rdy = 1; st_ack = 0;
      set_head(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      tick(); tick();
      rst = 0;
      set_head(1, 1, 3, 5, 32'h1234, 0, 0, 0, 0); tick();
      set_head(1, 1, 4, 0, 32'h55, 0, 0, 0, 0); tick();
      set_head(1, 1, 5, 32, 32'h66, 0, 0, 0, 0); tick();
      set_head(1, 0, 6, 7, 32'h77, 0, 0, 0, 0); tick();
      set_head(0, 1, 6, 7, 32'h77, 0, 0, 0, 0); tick();
      set_head(1, 1, 7, 9, 32'h99, 1, 0, 0, 0); tick();
      for (int i = 0; i < 4; i++) tick();
      rdy = 0; tick(); tick(); rdy = 1;
      st_ack = 1; tick(); st_ack = 0;
      set_head(1, 1, 8, 1, 32'h44, 0, 1, 1, 32'h80); tick();
      set_head(1, 1, 9, 2, 32'h11, 0, 0, 0, 0); tick();
      rdy = 0; tick(); tick(); rdy = 1;
      tick(); tick(); tick();
      set_head(1, 1, 10, 3, 32'h22, 0, 1, 0, 32'h200); tick();
      set_head(1, 1, 11, 4, 32'h33, 1, 0, 0, 0); tick(); tick();
      rst = 1; tick(); rst = 0; tick();
      for (int i = 0; i < 400; i++) begin
         int r;
         rst = $urandom_range(0, 99) < 2;
         rdy = $urandom_range(0, 99) < 85;
         st_ack = $urandom_range(0, 99) < 35;
         r = $urandom_range(0, 3);
         set_head($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(0, 15),
                  r == 0 ? 0 : r == 1 ? 32 : $urandom_range(0, 63), $urandom,
                  $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3, $urandom_range(0, 1), $urandom);
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/commit_sequencer.md
COMMIT_SEQUENCER -- requirements
Module: commit_sequencer

Interface
REQ-001 SHALL have parameter ROB_ID_W, default 4: ROB id width.
REQ-002 SHALL have parameter REG_W, default 6: extended register number width; value 32 means no destination.
REQ-003 SHALL have parameter FLUSH_HOLD, default 2: idle cycles after a flush before commit resumes (range 1..15).
REQ-004 Ports: clk input 1 clock; rst input 1 reset, synchronous, active-high; rdy input 1 global enable.
REQ-005 Ports: head_valid input 1 ROB head occupied; head_done input 1 head result ready; head_id input ROB_ID_W head id; head_rd input REG_W destination; head_val input 32 result.
REQ-006 Ports: head_is_store input 1 head is a store; head_is_br input 1 head is a branch; head_miss input 1 branch mispredicted; head_tgt input 32 correct PC.
REQ-007 Ports: rob_pop output 1 retire head; rf_we output 1 register-file write enable; rf_rd output REG_W; rf_q output ROB_ID_W; rf_v output 32.
REQ-008 Ports: st_req output 1 store commit request; st_id output ROB_ID_W; st_ack input 1 memory accepted store.
REQ-009 Ports: mispredict output 1 global flush pulse; redirect_pc output 32; commit_cnt output 32 retired-instruction count.

Function
REQ-010 SHALL implement states IDLE, STORE_WAIT, FLUSH_HOLD.
REQ-011 When rdy=0, all state, counters and registered outputs SHALL hold, and single-cycle pulses (rob_pop, rf_we, mispredict) SHALL be 0.
REQ-012 In IDLE with head_valid and head_done and not a store or mispredicted branch: same cycle rob_pop=1; if head_rd not 0 and not 32, rf_we=1 with rf_rd=head_rd, rf_q=head_id, rf_v=head_val (combinational, zero latency); state stays IDLE.
REQ-013 Throughput SHALL be one retirement per cycle in IDLE.
REQ-014 In IDLE with a done store at head: rob_pop=0, st_req registered to 1 next cycle with st_id=head_id, go to STORE_WAIT.
REQ-015 In STORE_WAIT: st_req SHALL stay 1 until st_ack; on st_ack, st_req drops next cycle, rob_pop=1 in the ack cycle, return to IDLE; rf_we SHALL stay 0.
REQ-016 In IDLE with a done branch and head_miss=1: same cycle rob_pop=1, mispredict=1, redirect_pc=head_tgt, rf_we per REQ-012 rule (JAL/JALR link), then FLUSH_HOLD.
REQ-017 FLUSH_HOLD SHALL last exactly FLUSH_HOLD cycles (rdy-qualified), with rob_pop, rf_we, st_req and mispredict all 0, then return to IDLE.
REQ-018 redirect_pc SHALL be registered and hold its last value until the next mispredict.
REQ-019 commit_cnt SHALL increment by 1 on every rob_pop, wrapping 2^32-1 to 0.
REQ-020 head_done=0 or head_valid=0 in IDLE SHALL cause no output activity.
REQ-021 mispredict SHALL never assert in the same cycle as st_req rising or in STORE_WAIT.

Reset
REQ-022 On rst: state IDLE, st_req=0, st_id=0, redirect_pc=0, commit_cnt=0, hold counter 0; all combinational outputs 0.
REQ-023 rst SHALL take priority over rdy and abort STORE_WAIT or FLUSH_HOLD immediately without popping.

Structure
REQ-024 ROB_ID_W, REG_W, the no-destination code 32 and state encodings SHALL live in the shared define header.
REQ-025 Single module; no sub-module.

Verification
REQ-026 Reset, then ALU head (rd=5, id=3, val=0x1234, done) -> same cycle rob_pop=1, rf_we=1, rf_rd=5, rf_q=3, rf_v=0x1234; commit_cnt=1 next cycle.
REQ-027 Head rd=0, then rd=32 -> rob_pop=1, rf_we=0 both cycles.
REQ-028 Store head id=7, st_ack held low 4 cycles then 1 -> st_req high from cycle+1 through the ack cycle, rob_pop=1 only in the ack cycle, no rf_we.
REQ-029 Mispredicted branch tgt=0x80, rd=1, FLUSH_HOLD=2 -> mispredict=1 and rf_we=1 same cycle, redirect_pc=0x80, no pop for next 2 cycles even with ready head.
REQ-030 rdy=0 during STORE_WAIT and during FLUSH_HOLD -> state frozen, hold count extends by stalled cycles; rst mid-STORE_WAIT -> IDLE, st_req=0, commit_cnt=0.
